capture_seq: RTL and testbench
==============================

Name: capture_seq

Overview:
- Core-clock capture sequencer; owns the sample-memory write stream.
- Takes the sample depth, trigger position and trigger enable produced by the USB config block, already resynchronised into the core domain.
- Sequences one capture: pre-trigger fill, then a circular wait for trigger, then post-trigger count.
- Generates write enable/address for the sample buffer, records the trigger address, and flags completion to the config/readout side.

Parameters:
- DEPTH_W, 32, width of depth/position/address counters.

Ports:
- core_clk  in  1  core clock.
- core_rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle pulse; begins a capture from IDLE or DONE.
- abort  in  1  one-cycle pulse; terminates any capture.
- trig_en  in  1  trigger enable; sampled at start.
- sample_depth  in  DEPTH_W  total samples to store; sampled at start.
- trig_set_pos  in  DEPTH_W  pre-trigger sample count; sampled at start.
- sample_valid  in  1  one new sample this cycle (divider strobe).
- trig_hit  in  1  trigger condition true for the current sample.
- wr_en  out  1  write current sample to buffer.
- wr_addr  out  DEPTH_W  buffer address for the current write.
- triggered  out  1  high from the trigger sample until the next start, abort or reset.
- trig_addr  out  DEPTH_W  wr_addr of the trigger sample.
- capture_done  out  1  level, high in DONE.
- busy  out  1  high in PRE, WAIT_TRIG and POST.

Behaviour:
- Reset (core_rst high at a clock edge): state IDLE.
- Reset values: all outputs 0; internal latches and counters 0.
- States: IDLE, PRE, WAIT_TRIG, POST, DONE.
- wr_en is combinational: sample_valid & (state in PRE, WAIT_TRIG, POST). It has zero latency; wr_addr is the registered address used for that write.
- Start, from IDLE or DONE:
  - latch depth = sample_depth;
  - latch pos = min(trig_set_pos, depth-1), or 0 if depth==0;
  - clear wr_addr, triggered, trig_addr.
  - Next state:
    - depth==0 -> DONE;
    - !trig_en -> POST, with rem=depth, triggered=1, trig_addr=0;
    - trig_en & pos==0 -> WAIT_TRIG;
    - otherwise -> PRE.
  - start is ignored in PRE, WAIT_TRIG and POST.
- Abort: from any state -> IDLE next cycle; capture_done stays 0; wr_en is 0 in that cycle and after. Abort wins over a simultaneous start.
- PRE:
  - each sample_valid increments wr_addr and a fill counter; trig_hit is ignored.
  - When the fill counter reaches pos on a write -> WAIT_TRIG.
- WAIT_TRIG:
  - every sample_valid writes; wr_addr increments and wraps to 0 after depth-1.
  - sample_valid & trig_hit:
    - this sample is written and is the trigger sample;
    - trig_addr <= wr_addr; triggered <= 1; rem <= depth-pos-1;
    - next state POST, or DONE if depth-pos-1 == 0.
  - trig_hit without sample_valid has no effect.
- POST:
  - each sample_valid writes, increments wr_addr (with wrap) and decrements rem.
  - The write taking rem to 0 -> DONE.
- DONE: capture_done=1; wr_en=0; wr_addr, trig_addr and triggered are held.
- Arithmetic: all counters are unsigned DEPTH_W; the wrap compare is done against depth-1, not by natural overflow.
- Oldest sample after a triggered capture: (trig_addr - pos) mod depth. Readout computes this; this block does not.

Decomposition:
- Shared package cap_pkg: state enum (IDLE=0, PRE=1, WAIT_TRIG=2, POST=3, DONE=4, encoded 3-bit) and DEPTH_W default.
- One natural sub-module: wrap_cnt, an increment-with-wrap-at-limit counter with load/clear. It is used for wr_addr; the fill and rem counters are inline.

Test Plan:
- trig_en=0, depth=8, start, sample_valid every cycle -> 8 writes at addr 0..7; triggered=1 and trig_addr=0 from the cycle after start; capture_done rises the cycle after the 8th write.
- trig_en=1, depth=8, pos=3, trig_hit on the 6th sample -> 3 PRE writes at 0..2; WAIT_TRIG writes at 3,4; trigger at addr 5, so trig_addr=5; 4 post writes at 6,7,0,1; then done.
- trig_en=1, depth=4, pos=2, no trigger for 10 samples, then trig_hit -> wr_addr cycles 0,1,2,3,0,... with no done before the trigger; exactly 1 post write after the trigger sample.
- Edge sizes:
  - pos=9 with depth=8 -> clamped to 7; after the trigger sample, DONE next cycle.
  - depth=0 -> DONE one cycle after start, no writes.
- sample_valid every 3rd cycle with trig_hit held high between strobes -> trigger taken only on a strobe cycle.
- Abort in POST with rem=3, with start in the same cycle -> IDLE; no further wr_en; capture_done=0. A subsequent start restarts with wr_addr=0.
- core_rst asserted mid-WAIT_TRIG -> all outputs 0 at the next edge; state IDLE.

Source files
------------

// File: rtl/cap_pkg.sv
// cap_pkg: shared state encoding and default counter width for the capture sequencer.
package cap_pkg;
    localparam int DEPTH_W_DEF = 32;
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRE       = 3'd1,
        WAIT_TRIG = 3'd2,
        POST      = 3'd3,
        DONE      = 3'd4
    } state_t;
endpackage

// File: rtl/wrap_cnt.sv
// wrap_cnt: counter that increments and wraps to 0 after reaching limit, with clear and load.
module wrap_cnt #(
    parameter int W = 32
) (
    input  logic         core_clk,
    input  logic         core_rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    input  logic [W-1:0] limit,
    output logic [W-1:0] cnt
);
    always_ff @(posedge core_clk) begin
        if (core_rst || clr) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (inc) cnt <= (cnt == limit) ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/capture_seq.sv
// capture_seq: sequences pre-trigger fill, circular trigger wait and post-trigger count
// for the sample buffer write stream.
module capture_seq
    import cap_pkg::*;
#(
    parameter int DEPTH_W = DEPTH_W_DEF
) (
    input  logic               core_clk,
    input  logic               core_rst,
    input  logic               start,
    input  logic               abort,
    input  logic               trig_en,
    input  logic [DEPTH_W-1:0] sample_depth,
    input  logic [DEPTH_W-1:0] trig_set_pos,
    input  logic               sample_valid,
    input  logic               trig_hit,
    output logic               wr_en,
    output logic [DEPTH_W-1:0] wr_addr,
    output logic               triggered,
    output logic [DEPTH_W-1:0] trig_addr,
    output logic               capture_done,
    output logic               busy
);
    state_t state, state_d;
    logic [DEPTH_W-1:0] depth_q, pos_q, fill_q, rem_q, pos_new, post_n;
    logic go, hit;

    // Pre-trigger count can never cover the whole buffer: at least the trigger sample must fit.
    assign pos_new = (sample_depth == '0) ? '0 :
                     (trig_set_pos > sample_depth - 1'b1) ? sample_depth - 1'b1 : trig_set_pos;
    assign post_n = depth_q - pos_q - 1'b1;
    assign busy = (state == PRE) || (state == WAIT_TRIG) || (state == POST);
    assign capture_done = (state == DONE);
    assign go = start && !abort && ((state == IDLE) || (state == DONE));
    assign wr_en = sample_valid && busy && !abort;
    assign hit = wr_en && trig_hit && (state == WAIT_TRIG);

    always_ff @(posedge core_clk) begin
        if (core_rst) state <= IDLE;
        else state <= state_d;
    end

    always_comb begin
        state_d = state;
        if (abort) state_d = IDLE;
        else if (go) state_d = (sample_depth == '0) ? DONE :
                               !trig_en ? POST :
                               (pos_new == '0) ? WAIT_TRIG : PRE;
        else if (wr_en) begin
            if (state == PRE && fill_q + 1'b1 == pos_q) state_d = WAIT_TRIG;
            if (hit) state_d = (post_n == '0) ? DONE : POST;
            if (state == POST && rem_q == DEPTH_W'(1)) state_d = DONE;
        end
    end

    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            depth_q   <= '0;
            pos_q     <= '0;
            fill_q    <= '0;
            rem_q     <= '0;
            triggered <= 1'b0;
            trig_addr <= '0;
        end else if (abort) begin
            triggered <= 1'b0;
        end else if (go) begin
            depth_q   <= sample_depth;
            pos_q     <= pos_new;
            fill_q    <= '0;
            rem_q     <= sample_depth;
            triggered <= !trig_en && (sample_depth != '0);
            trig_addr <= '0;
        end else if (wr_en) begin
            if (state == PRE) fill_q <= fill_q + 1'b1;
            if (state == POST) rem_q <= rem_q - 1'b1;
            if (hit) begin
                trig_addr <= wr_addr;
                triggered <= 1'b1;
                rem_q     <= post_n;
            end
        end
    end

    wrap_cnt #(.W(DEPTH_W)) u_addr (
        .core_clk (core_clk),
        .core_rst (core_rst),
        .clr      (go),
        .load     (1'b0),
        .load_val ('0),
        .inc      (wr_en),
        .limit    (depth_q - 1'b1),
        .cnt      (wr_addr)
    );
endmodule

// File: tb/tb_capture_seq.sv
// tb_capture_seq: checks capture_seq every cycle against a write-count based model,
// with directed scenarios pinned by literal expectations and a randomized phase.
module tb_capture_seq;
    logic        core_clk = 0;
    logic        core_rst = 1;
    logic        start = 0, abort = 0, trig_en = 0, sample_valid = 0, trig_hit = 0;
    logic [31:0] sample_depth = 0, trig_set_pos = 0;
    logic        wr_en, triggered, capture_done, busy;
    logic [31:0] wr_addr, trig_addr;

    int total = 0, bad = 0;
    int wq[$];

    // model: progress is tracked as the number of writes since start
    bit m_active = 0, m_done = 0, m_te = 0, m_trg = 0;
    int m_depth = 0, m_pos = 0, m_n = 0, m_tat = -1, m_taddr = 0;

    capture_seq #(.DEPTH_W(32)) dut (
        .core_clk(core_clk), .core_rst(core_rst), .start(start), .abort(abort),
        .trig_en(trig_en), .sample_depth(sample_depth), .trig_set_pos(trig_set_pos),
        .sample_valid(sample_valid), .trig_hit(trig_hit), .wr_en(wr_en), .wr_addr(wr_addr),
        .triggered(triggered), .trig_addr(trig_addr), .capture_done(capture_done), .busy(busy)
    );

    always #5 core_clk = ~core_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge core_clk);
        chk("wr_en", {31'd0, wr_en}, {31'd0, sample_valid & m_active & !abort});
        chk("wr_addr", wr_addr, (m_depth == 0) ? 0 : m_n % m_depth);
        chk("triggered", {31'd0, triggered}, {31'd0, m_trg});
        chk("trig_addr", trig_addr, m_taddr);
        chk("capture_done", {31'd0, capture_done}, {31'd0, m_done});
        chk("busy", {31'd0, busy}, {31'd0, m_active});
        if (wr_en === 1'b1) wq.push_back(int'(wr_addr));
        if (core_rst) begin
            m_active = 0; m_done = 0; m_trg = 0; m_taddr = 0; m_n = 0; m_depth = 0; m_pos = 0;
        end else if (abort) begin
            m_active = 0; m_done = 0; m_trg = 0;
        end else if (start && !m_active) begin
            m_depth = int'(sample_depth);
            m_pos = (m_depth == 0) ? 0 : (int'(trig_set_pos) > m_depth - 1 ? m_depth - 1 : int'(trig_set_pos));
            m_te = trig_en; m_n = 0; m_taddr = 0; m_tat = -1;
            m_trg = !trig_en && m_depth > 0;
            m_active = m_depth > 0; m_done = m_depth == 0;
        end else if (m_active && sample_valid) begin
            if (m_te && m_tat < 0 && m_n >= m_pos && trig_hit) begin
                m_tat = m_n; m_trg = 1; m_taddr = m_n % m_depth;
            end
            m_n++;
            if (m_te ? (m_tat >= 0 && m_n == m_tat + m_depth - m_pos) : (m_n == m_depth)) begin
                m_active = 0; m_done = 1;
            end
        end
    end

    task automatic step(input logic s, input logic a, input logic v, input logic h);
        start = s; abort = a; sample_valid = v; trig_hit = h;
        @(posedge core_clk);
        #1;
    endtask

    task automatic cfg(input logic te, input int d, input int p);
        trig_en = te; sample_depth = d; trig_set_pos = p;
    endtask

    task automatic chk_q(input string name, input int exp[$]);
        chk({name, "_count"}, wq.size(), exp.size());
        foreach (exp[i]) if (i < wq.size()) chk(name, wq[i], exp[i]);
    endtask

    initial begin
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        core_rst = 0;
        // no trigger: plain post capture of depth 8
        cfg(0, 8, 0); wq.delete();
        step(1, 0, 1, 0);
        chk("t1_triggered", {31'd0, triggered}, 1);
        chk("t1_trig_addr", trig_addr, 0);
        repeat (8) step(0, 0, 1, 0);
        chk("t1_done", {31'd0, capture_done}, 1);
        step(0, 0, 1, 0);
        chk_q("t1_addr", '{0, 1, 2, 3, 4, 5, 6, 7});
        // pre 3, trigger on the 6th sample
        cfg(1, 8, 3); wq.delete();
        step(1, 0, 0, 0);
        repeat (5) step(0, 0, 1, 0);
        step(0, 0, 1, 1);
        chk("t2_trig_addr", trig_addr, 5);
        repeat (6) step(0, 0, 1, 0);
        chk("t2_done", {31'd0, capture_done}, 1);
        chk_q("t2_addr", '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1});
        // circular wait with wrap before trigger
        cfg(1, 4, 2); wq.delete();
        step(1, 0, 0, 0);
        repeat (12) step(0, 0, 1, 0);
        chk("t3_not_done", {31'd0, capture_done}, 0);
        step(0, 0, 1, 1);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        chk("t3_done", {31'd0, capture_done}, 1);
        chk_q("t3_addr", '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3, 0, 1});
        // pos clamp
        cfg(1, 8, 9); wq.delete();
        step(1, 0, 0, 0);
        repeat (7) step(0, 0, 1, 0);
        step(0, 0, 1, 1);
        chk("t4_done", {31'd0, capture_done}, 1);
        chk("t4_trig_addr", trig_addr, 7);
        // zero depth
        cfg(1, 0, 0); wq.delete();
        step(1, 0, 1, 0);
        chk("t5_done", {31'd0, capture_done}, 1);
        step(0, 0, 1, 1);
        chk("t5_writes", wq.size(), 0);
        // sparse strobes, trig_hit held high
        cfg(1, 8, 2); wq.delete();
        step(1, 0, 0, 0);
        repeat (6) step(0, 0, 1, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 1);
            step(0, 0, 0, 1);
            step(0, 0, 1, 1);
        end
        chk("t6_trig_addr", trig_addr, 2);
        // abort in post with rem 3 plus simultaneous start
        cfg(0, 5, 0); wq.delete();
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(1, 1, 1, 0);
        chk("t7_busy", {31'd0, busy}, 0);
        chk("t7_done", {31'd0, capture_done}, 0);
        repeat (4) step(0, 0, 1, 0);
        chk("t7_writes", wq.size(), 2);
        cfg(0, 4, 0);
        step(1, 0, 0, 0);
        chk("t7_restart_addr", wr_addr, 0);
        chk("t7_restart_busy", {31'd0, busy}, 1);
        repeat (5) step(0, 0, 1, 0);
        // reset mid wait
        cfg(1, 8, 1);
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        core_rst = 1;
        step(0, 0, 1, 0);
        chk("t8_rst", {wr_addr, trig_addr} | {31'd0, wr_en, triggered, capture_done, busy}, 0);
        core_rst = 0;
        // randomized phase
        for (int i = 0; i < 4000; i++) begin
            cfg($urandom_range(3) != 0, $urandom_range(10), $urandom_range(12));
            core_rst = ($urandom_range(499) == 0);
            step($urandom_range(15) == 0, $urandom_range(99) == 0,
                 $urandom_range(1) == 1, $urandom_range(7) == 0);
        end
        core_rst = 0;
        step(0, 0, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
